// File: rtl/aes256_round_ctrl.sv
// Word-serial AES-256 encryption sequencer: walks rounds 0..14 one column per cycle,
// feeding an external S-box and a shared mix_w column unit from the held cipher state.
module aes256_round_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in_block,
    output logic         busy,
    output logic         done,
    output logic [127:0] out_block,
    output logic [3:0]   rk_round,
    output logic [1:0]   rk_word,
    input  logic [31:0]  rk_data,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic [3:0]   mix_round,
    output logic [31:0]  mix_key,
    output logic [31:0]  mix_in,
    input  logic [31:0]  mix_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t fsm, fsm_nxt;

    // state[3-c] is column c and state[3-c][3-b] is byte b of that column,
    // so column 0 occupies [127:96] with its byte 0 at [127:120].
    logic [3:0][3:0][7:0] state;
    logic [2:0][31:0]     nxt;
    logic [3:0]           round;
    logic [1:0]           word;
    logic                 last;

    assign last = (round == 4'd14) && (word == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        fsm_nxt = fsm;
        busy    = 1'b0;
        done    = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) fsm_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) fsm_nxt = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= '0;
            nxt       <= '0;
            round     <= '0;
            word      <= '0;
            out_block <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state <= in_block;
                        round <= 4'd0;
                        word  <= 2'd0;
                    end
                end
                RUN: begin
                    // The whole state is replaced only once the round's fourth
                    // column is done, because ShiftRows reads every column.
                    case (word)
                        2'd0: nxt[2] <= mix_out;
                        2'd1: nxt[1] <= mix_out;
                        2'd2: nxt[0] <= mix_out;
                        default: begin
                            state <= {nxt, mix_out};
                            if (round == 4'd14) out_block <= {nxt, mix_out};
                            else                round     <= round + 4'd1;
                        end
                    endcase
                    word <= word + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign rk_round  = round;
    assign rk_word   = word;
    assign mix_round = round;
    assign mix_key   = rk_data;

    // ShiftRows: row b of output column j comes from column (j+b) mod 4;
    // the 2-bit sums wrap naturally.
    assign sb_in = {state[~word][3],
                    state[~(word + 2'd1)][2],
                    state[~(word + 2'd2)][1],
                    state[~(word + 2'd3)][0]};

    assign mix_in = (fsm != RUN || round == 4'd0) ? state[~word] : sb_out;

endmodule

// File: tb/tb_aes256_round_ctrl.sv
// Directed bench for aes256_round_ctrl: models the S-box, mix_w and key-schedule RAM
// around the sequencer and checks ciphertexts, key-port order, timing and reset.
module tb_aes256_round_ctrl;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] in_block;
    logic         busy;
    logic         done;
    logic [127:0] out_block;
    logic [3:0]   rk_round;
    logic [1:0]   rk_word;
    logic [31:0]  rk_data;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;
    logic [3:0]   mix_round;
    logic [31:0]  mix_key;
    logic [31:0]  mix_in;
    logic [31:0]  mix_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;

    logic [7:0]  sbox [0:255];
    logic [31:0] w    [0:63];

    aes256_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_block  (in_block),
        .busy      (busy),
        .done      (done),
        .out_block (out_block),
        .rk_round  (rk_round),
        .rk_word   (rk_word),
        .rk_data   (rk_data),
        .sb_in     (sb_in),
        .sb_out    (sb_out),
        .mix_round (mix_round),
        .mix_key   (mix_key),
        .mix_in    (mix_in),
        .mix_out   (mix_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] x);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = x;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h01;
            if (a == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic set_key(input logic [255:0] key);
        logic [7:0] rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            logic [31:0] t;
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 60; i < 64; i++) w[i] = '0;
    endtask

    // Peripheral models: combinational key RAM, S-box and mix_w column unit.
    assign rk_data = w[{rk_round, rk_word}];
    assign sb_out  = sub_word(sb_in);
    assign mix_out = (mix_round == 4'd0 || mix_round == 4'd14) ? (mix_in ^ mix_key)
                                                               : (mix_col(mix_in) ^ mix_key);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start, walks the 60 RUN cycles checking the key port and held output,
    // then checks the DONE cycle (T+61) and the return to IDLE (T+62).
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] ct,
                             input logic [127:0] hold, input bit inject);
        int seq_err = 0;
        int hold_err = 0;
        int done_base;
        done_base = done_cnt;
        in_block = pt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (!busy || done) seq_err++;
            if (rk_round != 4'((c - 1) / 4) || rk_word != 2'((c - 1) % 4)) seq_err++;
            if (mix_round != rk_round || mix_key != rk_data) seq_err++;
            if (out_block != hold) hold_err++;
            if (inject && c == 5) begin
                in_block = ~pt;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_done_t61"}, 128'(done), 128'd1);
        check({tag, "_busy_t61"}, 128'(busy), 128'd1);
        check({tag, "_ct"}, out_block, ct);
        if (inject) begin
            in_block = ~pt;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        check({tag, "_busy_t62"}, 128'(busy), 128'd0);
        check({tag, "_done_t62"}, 128'(done), 128'd0);
        check({tag, "_ct_held"}, out_block, ct);
        check({tag, "_keyseq_errs"}, 128'(seq_err), 128'd0);
        check({tag, "_hold_errs"}, 128'(hold_err), 128'd0);
        check({tag, "_done_pulses"}, 128'(done_cnt - done_base), 128'd1);
    endtask

    initial begin
        int d1;
        int base;
        rst = 1'b1;
        start = 1'b0;
        in_block = '0;
        build_sbox();
        set_key(KEY_C3);
        tick();
        tick();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_out", out_block, 128'd0);
        check("rst_rk", 128'({rk_round, rk_word, mix_round}), 128'd0);
        rst = 1'b0;
        tick();

        // FIPS-197 C.3 vector.
        run_block("c3", PT_C3, CT_C3, 128'd0, 1'b0);
        d1 = last_done_cyc;

        // Back-to-back: second start in cycle T+62, all-zero key and plaintext.
        set_key('0);
        run_block("zero_b2b", 128'd0, CT_ZERO, CT_C3, 1'b0);
        check("b2b_done_spacing", 128'(last_done_cyc - d1), 128'd62);

        // Starts during RUN (T+5) and DONE (T+61) must be ignored.
        set_key(KEY_C3);
        run_block("c3_ignore", PT_C3, CT_C3, CT_ZERO, 1'b1);
        base = done_cnt;
        repeat (70) tick();
        check("ignore_idle_busy", 128'(busy), 128'd0);
        check("ignore_no_extra_done", 128'(done_cnt - base), 128'd0);

        // Reset in cycle T+30 aborts the block.
        in_block = PT_C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_out", out_block, 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_rk", 128'({rk_round, rk_word}), 128'd0);
        base = done_cnt;
        repeat (70) tick();
        check("abort_no_done", 128'(done_cnt - base), 128'd0);
        run_block("c3_after_abort", PT_C3, CT_C3, 128'd0, 1'b0);

        // start together with rst: reset wins.
        rst = 1'b1;
        start = 1'b1;
        in_block = PT_C3;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 128'(busy), 128'd0);
        check("rst_start_out", out_block, 128'd0);
        tick();
        check("rst_start_busy_next", 128'(busy), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes256_round_ctrl.md
# aes256_round_ctrl

Word-serial round sequencer for AES-256 encryption. It owns the 128-bit cipher state and drives one shared `mix_w` instance plus one external 32-bit S-box word, one column per cycle, through rounds 0..14. Round keys are fetched word by word from the key-schedule storage. It sits between the block-level host handshake and the word datapath (`mix_w`, S-box, key RAM).

## Interface
Parameters: none.

- `clk`  in  1  — the block's single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — begin encryption of `in_block`; accepted only in IDLE.
- `in_block`  in  128  — plaintext; word 0 = [127:96], byte 0 of each word = [31:24].
- `busy`  out  1  — high in RUN and DONE.
- `done`  out  1  — one-cycle pulse when `out_block` is updated.
- `out_block`  out  128  — ciphertext register; held until the next `done`.
- `rk_round`  out  4  — round-key index requested (0..14).
- `rk_word`  out  2  — word index within the round key (0..3).
- `rk_data`  in  32  — round-key word; combinationally valid in the same cycle as `rk_round`/`rk_word`.
- `sb_in`  out  32  — ShiftRows-selected word, sent to the S-box.
- `sb_out`  in  32  — S-box result of `sb_in`; combinational, same cycle.
- `mix_round`  out  4  — connects to `mix_w.round`.
- `mix_key`  out  32  — connects to `mix_w.round_key`; equals `rk_data`.
- `mix_in`  out  32  — connects to `mix_w.in`.
- `mix_out`  in  32  — connects to `mix_w.out`.

## Operation
- Registers:
  - `state[127:0]` holds the current round input.
  - `nxt[95:0]` holds the words 0..2 results of the current round.
  - `round[3:0]`, `word[1:0]`, a 2-bit FSM, and `out_block`.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. In that transition: `state` ← `in_block`, `round` ← 0, `word` ← 0.
  - RUN → DONE after round 14, word 3 is processed.
  - DONE → IDLE unconditionally. `start` is ignored in RUN and DONE.
- Per RUN cycle, with r = `round` and j = `word`:
  - `rk_round` = r, `rk_word` = j, `mix_round` = r, `mix_key` = `rk_data`.
  - Byte s[b][c] is byte b of state word c.
  - `sb_in` = {s[0][j], s[1][(j+1)%4], s[2][(j+2)%4], s[3][(j+3)%4]} (ShiftRows), with indices taken mod 4.
  - `mix_in` = state word j when r = 0; otherwise `sb_out`.
  - `mix_w` performs only the AddRoundKey bypass for rounds 0 and 14, so no special-casing is needed here.
- Word-result capture:
  - j < 3: `nxt` word j ← `mix_out`.
  - j = 3: `state` ← {`nxt`, `mix_out`}, `word` ← 0, and `round` increments. If r = 14, `round` is not incremented, `out_block` ← {`nxt`, `mix_out`}, and the FSM goes to DONE.
  - `state` is never partially overwritten mid-round, because ShiftRows reads all four columns.
- `done` = 1 only in DONE. `busy` = 1 in RUN and DONE.
- Outputs in IDLE and DONE:
  - `rk_round`, `rk_word`, and `mix_round` show the registered counters.
  - `sb_in` and `mix_in` are driven from `state`.
  - These values are don't-care to consumers.
- Counter arithmetic: unsigned. `word` wraps 3 → 0. `round` never exceeds 14.

## Timing
- Reset (`rst` high at a clock edge) produces:
  - FSM = IDLE, `round` = 0, `word` = 0.
  - `state` = 0, `nxt` = 0, `out_block` = 0.
  - `busy` = 0, `done` = 0.
  - Therefore `rk_round` = 0, `rk_word` = 0, `mix_round` = 0.
- Reset mid-operation aborts the current block, with no `done` pulse.
- Latency: `start` sampled at edge T. RUN covers cycles T+1..T+60 (15 rounds × 4 words). `done` is high in cycle T+61, and `out_block` is valid from that cycle onward.
- Throughput: one block per 62 cycles. A new `start` is accepted from cycle T+62 (IDLE).
- `start` asserted in the same cycle as `rst`: reset wins.
- The key request is purely combinational from the counters. Key storage must return `rk_data` in the same cycle. There are no stall or handshake inputs.

## Test plan
- FIPS-197 C.3: key 000102…1e1f (the bench's key-schedule model feeds `rk_data`), `in_block` = 00112233445566778899aabbccddeeff → `done` at T+61, `out_block` = 8ea2b7ca516745bfeafc49904b496089.
- All-zero key and all-zero plaintext → `out_block` = dc95c078a2408989ad48a21492842087.
- Key-port sequence: during RUN, the sampled {`rk_round`, `rk_word`} go (0,0),(0,1)…(14,3), exactly 60 cycles with no repeats. `mix_round` equals `rk_round` in every cycle.
- `start` pulsed at T+5 and at T+61 (DONE) with a different block → both ignored. The first result is correct, `busy` falls at T+62, and exactly one `done` pulse occurs.
- `rst` asserted at T+30 → next cycle: `busy` = 0, `out_block` = 0, no `done`. A following `start` with the C.3 vector yields the correct ciphertext.
- Back-to-back: two blocks, with the second `start` issued at T+62 → two `done` pulses 62 cycles apart, each with the correct ciphertext. The first `out_block` is held until the second `done`.
